fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Owns the program counter and sequences instruction fetch for the single-core pipeline.
//   Issues instruction-memory requests and holds one fetched instruction for decode.
//   Applies branch redirects resolved in EX (target = ExPC + (SignExtImm64<<2)), flushing wrong-path fetch.
//   Supports decode back-pressure, halt/resume and saturating fetch/redirect counters.
// PARAMETERS
//   RESET_PC  64'h0  PC value loaded on reset
//   CNT_W     32     width of FetchCount / RedirectCount
// PORTS
//   CLK            in   1      clock, all state on rising edge
//   Reset          in   1      asynchronous, active-high reset
//   Halt           in   1      1 = stop issuing new fetches
//   ImemReq        out  1      fetch request valid
//   ImemAddr       out  64     fetch address (= PC)
//   ImemAck        in   1      memory ready; transfer when ImemReq&&ImemAck
//   ImemData       in   32     instruction, valid in transfer cycle
//   IfValid        out  1      IfInstr/IfPC hold a valid instruction for decode
//   IfInstr        out  32     fetched instruction
//   IfPC           out  64     address of IfInstr
//   IdStall        in   1      decode not consuming this cycle
//   ExValid        in   1      EX stage holds a valid instruction
//   Branch         in   1      EX instr is conditional branch
//   Uncondbranch   in   1      EX instr is unconditional branch
//   ALUZero        in   1      EX zero flag
//   ExPC           in   64     PC of EX instr
//   SignExtImm64   in   64     sign-extended branch offset (words)
//   Flush          out  1      one-cycle pulse: kill IF/ID contents
//   FetchCount     out  CNT_W  accepted fetches
//   RedirectCount  out  CNT_W  redirects taken
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, PC=RESET_PC, IfValid=0, IfInstr=0, IfPC=0, Flush=0, counters=0.
//   States: IDLE -> FETCH on first edge with Halt=0; FETCH -> HALTED on edge with Halt=1;
//     HALTED -> FETCH on edge with Halt=0. IDLE/HALTED: ImemReq=0.
//   ImemReq = (state==FETCH) && (!IfValid || !IdStall); combinational, ImemAddr=PC always.
//   Dropping ImemReq before ack is legal; memory samples per cycle, no outstanding requests.
//   Transfer cycle (no redirect): next edge IfInstr<=ImemData, IfPC<=PC, IfValid<=1,
//     PC<=PC+4 (mod 2^64), FetchCount+1. Back-to-back transfers every cycle when ack=1, IdStall=0.
//   Consume: IfValid&&!IdStall with no transfer -> IfValid<=0 next edge.
//   IfValid&&IdStall: IfInstr/IfPC/IfValid held, no request issued.
//   Redirect = ExValid && (Uncondbranch || (Branch && ALUZero)); Branch/ALUZero ignored if Uncondbranch.
//   Redirect cycle N: edge N+1 PC<=ExPC+(SignExtImm64<<2) (64-bit wrap), IfValid<=0,
//     Flush<=1 for cycle N+1 only, RedirectCount+1; any transfer in cycle N is discarded
//     (PC not incremented, FetchCount unchanged). Redirect beats IdStall and Halt for PC/IfValid.
//   Redirect in IDLE/HALTED updates PC and pulses Flush; state unchanged.
//   Counters saturate at all-ones, never wrap.
//   Halt does not clear IfValid; held instruction drains normally.
// TESTING
//   Reset release, Halt=0, ImemAck=1, IdStall=0 -> ImemAddr 0,4,8 on successive cycles; IfPC 0,4 follow one cycle later; FetchCount=2 after 2 transfers.
//   IfValid=1, IdStall=1 for 3 cycles -> ImemReq=0, IfInstr/IfPC unchanged; IdStall=0 -> request at next PC resumes.
//   ExValid=1, Branch=1, ALUZero=1, ExPC=0x100, Imm=3 -> next cycle ImemAddr=0x10C, Flush=1 once, IfValid=0; ALUZero=0 -> no redirect, Flush=0.
//   Redirect coincident with transfer and IdStall=1 -> data discarded, FetchCount unchanged, RedirectCount+1, PC=target.
//   Uncondbranch, ExPC=0x4, Imm=-2 -> ImemAddr=64'hFFFF_FFFF_FFFF_FFFC; Halt=1 mid-stream -> ImemReq=0 after one edge, resumes at same PC.
//   Reset asserted mid-stall -> IfValid/Flush/counters 0 immediately; after release ImemAddr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues single-cycle imem requests,
// holds one fetched instruction for decode and applies EX-stage branch redirects.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Halt,
  output logic             ImemReq,
  output logic [63:0]      ImemAddr,
  input  logic             ImemAck,
  input  logic [31:0]      ImemData,
  output logic             IfValid,
  output logic [31:0]      IfInstr,
  output logic [63:0]      IfPC,
  input  logic             IdStall,
  input  logic             ExValid,
  input  logic             Branch,
  input  logic             Uncondbranch,
  input  logic             ALUZero,
  input  logic [63:0]      ExPC,
  input  logic [63:0]      SignExtImm64,
  output logic             Flush,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        transfer;
  logic        redirect;
  logic [63:0] target;

  // NOTE: the request is combinational so a consumed slot can be refilled in
  // the same cycle; memory samples it per cycle, nothing stays outstanding.
  assign ImemReq  = (state == FETCH) && (!IfValid || !IdStall);
  assign ImemAddr = pc;
  assign transfer = ImemReq && ImemAck;
  assign redirect = ExValid && (Uncondbranch || (Branch && ALUZero));
  assign target   = ExPC + (SignExtImm64 << 2);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      IfValid       <= 1'b0;
      IfInstr       <= 32'h0;
      IfPC          <= 64'h0;
      Flush         <= 1'b0;
      FetchCount    <= '0;
      RedirectCount <= '0;
    end else begin
      case (state)
        IDLE:    if (!Halt) state <= FETCH;
        FETCH:   if (Halt)  state <= HALTED;
        HALTED:  if (!Halt) state <= FETCH;
        default: state <= IDLE;
      endcase

      Flush <= redirect;

      // A redirect wins over both a same-cycle transfer and a decode stall.
      if (redirect) begin
        pc      <= target;
        IfValid <= 1'b0;
        if (RedirectCount != '1) RedirectCount <= RedirectCount + 1'b1;
      end else if (transfer) begin
        IfInstr <= ImemData;
        IfPC    <= pc;
        IfValid <= 1'b1;
        pc      <= pc + 64'd4;
        if (FetchCount != '1) FetchCount <= FetchCount + 1'b1;
      end else if (IfValid && !IdStall) begin
        IfValid <= 1'b0;
      end
    end
  end

endmodule
